// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data/stack port and the memory-side bus of
//   mem_port_arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, read data, memory bus out)
//   master : environment view (CPU stages plus memory array)
//   Fetch  : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   Data   : d_req, d_addr, d_we, d_wdata, d_lock -> d_gnt, d_rvalid, d_rdata
//   Memory : mem_addr, mem_we, mem_wdata -> mem_rdata
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_lock, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_lock, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-addressed memory between the instruction-fetch port
//   (read only) and the data/stack port (read/write). Round-robin req/gnt
//   arbitration; grants are combinational, read data is returned one cycle
//   after the grant with a per-port rvalid pulse.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : mem_port_arbiter_if.slave (fetch, data and memory signals)
//   Configuration macro: MEM_ARB_LOCK_EN
//     defined   : d_lock honoured, D_LOCK state and LOCK_MAX counter built
//     undefined : d_lock ignored, pure round-robin
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no grant since reset; fetch wins the first tie
//   F_LAST | fetch won last; data wins the next tie
//   D_LAST | data won last; fetch wins the next tie
//   D_LOCK | data holds a lock; data wins ties until the counter hits LOCK_MAX
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    F_LAST = 2'b01,
    D_LAST = 2'b10,
    D_LOCK = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] r_lock_cnt;
  logic             w_lock_full;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    F_LAST = 2'b01,
    D_LAST = 2'b10
  } state_t;
`endif

  state_t            r_state;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_fetch_wins;
  logic              w_i_gnt;
  logic              w_d_gnt;

`ifdef MEM_ARB_LOCK_EN
  assign w_lock_full = (r_lock_cnt == CNT_W'(LOCK_MAX));
`else
  // d_lock and LOCK_MAX have no function in the plain round-robin build.
  logic w_unused;
  assign w_unused = bus.d_lock ^ (LOCK_MAX != 0);
`endif

  // Tie-break: whoever did not win last; a held lock keeps data ahead until
  // the counter saturates, then fetch is forced through.
  always_comb begin
    w_fetch_wins = (r_state != F_LAST);
`ifdef MEM_ARB_LOCK_EN
    if (r_state == D_LOCK) begin
      w_fetch_wins = w_lock_full;
    end
`endif
  end

  // Grants are masked during reset so every output reads 0 immediately.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        w_i_gnt = w_fetch_wins;
        w_d_gnt = !w_fetch_wins;
      end else begin
        w_i_gnt = bus.i_req;
        w_d_gnt = bus.d_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
`ifdef MEM_ARB_LOCK_EN
      r_lock_cnt <= '0;
`endif
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_d_rvalid <= w_d_gnt && !bus.d_we;
      if (w_i_gnt) begin
        r_i_rdata <= bus.mem_rdata;
      end
      if (w_d_gnt && !bus.d_we) begin
        r_d_rdata <= bus.mem_rdata;
      end

      if (w_i_gnt) begin
        r_state <= F_LAST;
`ifdef MEM_ARB_LOCK_EN
        r_lock_cnt <= '0;
`endif
      end else if (w_d_gnt) begin
`ifdef MEM_ARB_LOCK_EN
        if (bus.d_lock) begin
          r_state <= D_LOCK;
          // The grant that takes the lock counts as the first locked grant.
          if (r_state != D_LOCK) begin
            r_lock_cnt <= CNT_W'(1);
          end else if (!w_lock_full) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end
        end else begin
          r_state    <= D_LAST;
          r_lock_cnt <= '0;
        end
`else
        r_state <= D_LAST;
`endif
      end
`ifdef MEM_ARB_LOCK_EN
      else if ((r_state == D_LOCK) && !bus.d_req) begin
        r_state    <= D_LAST;
        r_lock_cnt <= '0;
      end
`endif
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.i_rvalid  = r_i_rvalid;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = w_i_gnt ? bus.i_addr : (w_d_gnt ? bus.d_addr : '0);
  assign bus.mem_we    = w_d_gnt && bus.d_we;
  assign bus.mem_wdata = reset ? '0 : bus.d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a 256-byte big-endian memory model.
//   Follows MEM_ARB_LOCK_EN for the expected lock sequence.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  logic [7:0] w_ra;
  always_comb begin
    w_ra = bus.mem_addr[7:0];
    bus.mem_rdata = {mem[w_ra], mem[w_ra + 8'd1], mem[w_ra + 8'd2], mem[w_ra + 8'd3]};
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]]         = bus.mem_wdata[31:24];
      mem[bus.mem_addr[7:0] + 8'd1]  = bus.mem_wdata[23:16];
      mem[bus.mem_addr[7:0] + 8'd2]  = bus.mem_wdata[15:8];
      mem[bus.mem_addr[7:0] + 8'd3]  = bus.mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_addr  = '0;
    bus.d_we    = 1'b0;
    bus.d_wdata = '0;
    bus.d_lock  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] prev;
    logic       exp_i;
    logic       lock_build;
    n_chk  = 0;
    n_pass = 0;
`ifdef MEM_ARB_LOCK_EN
    lock_build = 1'b1;
`else
    lock_build = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]  = 8'h55; mem[1]  = 8'h89; mem[2]  = 8'hE5; mem[3]  = 8'h8B;
    mem[4]  = 8'h01; mem[5]  = 8'h02; mem[6]  = 8'h03; mem[7]  = 8'h04;
    mem[64] = 8'hAA; mem[65] = 8'hBB; mem[66] = 8'hCC; mem[67] = 8'hDD;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_req = 1'b1;
    #1;
    check("rst_gnt_masked", 32'(bus.i_gnt), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);

    // fetch only
    reset = 1'b0;
    bus.i_addr = 32'h0;
    @(negedge clk);
    check("f_i_gnt", 32'(bus.i_gnt), 32'd1);
    check("f_d_gnt", 32'(bus.d_gnt), 32'd0);
    @(posedge clk); #1;
    check("f_i_rvalid", 32'(bus.i_rvalid), 32'd1);
    check("f_i_rdata", bus.i_rdata, 32'h5589E58B);

    // reset mid-cycle while a read is in flight and rvalid is high
    bus.i_addr = 32'h4;
    @(negedge clk);
    check("r_pre_mem_addr", bus.mem_addr, 32'h4);
    #1 reset = 1'b1;
    #1;
    check("r_i_gnt", 32'(bus.i_gnt), 32'd0);
    check("r_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("r_i_rdata", bus.i_rdata, 32'd0);
    check("r_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'h40;
    @(negedge clk);
    check("r_tie_i_gnt", 32'(bus.i_gnt), 32'd1);
    check("r_tie_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("r_tie_mem_addr", bus.mem_addr, 32'h0);

    // contention: alternation I,D,I,D,I,D
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'h40;
    prev = 2'd0;
    for (int k = 0; k < 6; k++) begin
      exp_i = (k % 2 == 0);
      @(negedge clk);
      check($sformatf("c%0d_i_gnt", k), 32'(bus.i_gnt), 32'(exp_i));
      check($sformatf("c%0d_d_gnt", k), 32'(bus.d_gnt), 32'(!exp_i));
      check($sformatf("c%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'(prev == 2'd1));
      check($sformatf("c%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'(prev == 2'd2));
      if (prev == 2'd1) check($sformatf("c%0d_i_rdata", k), bus.i_rdata, 32'h5589E58B);
      if (prev == 2'd2) check($sformatf("c%0d_d_rdata", k), bus.d_rdata, 32'hAABBCCDD);
      prev = exp_i ? 2'd1 : 2'd2;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    check("c_end_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("c_end_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("c_end_d_rdata", bus.d_rdata, 32'hAABBCCDD);
    check("c_end_mem_addr", bus.mem_addr, 32'd0);
    check("c_end_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;

    // write then read
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("w_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("w_mem_we", 32'(bus.mem_we), 32'd1);
    check("w_mem_addr", bus.mem_addr, 32'h10);
    check("w_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("w_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("w_mem_we_off", 32'(bus.mem_we), 32'd0);
    check("w_d_rdata_held", bus.d_rdata, 32'hAABBCCDD);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    @(negedge clk);
    check("rd_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("rd_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rd_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("rd_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_rvalid_pulse", 32'(bus.d_rvalid), 32'd0);
    check("rd_rdata_hold", bus.d_rdata, 32'hDEADBEEF);

    // lock: I, then 8 data grants, then forced fetch (plain build alternates)
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_i = lock_build ? (k == 0 || k == 9) : (k % 2 == 0);
      @(negedge clk);
      check($sformatf("l%0d_i_gnt", k), 32'(bus.i_gnt), 32'(exp_i));
      check($sformatf("l%0d_d_gnt", k), 32'(bus.d_gnt), 32'(!exp_i));
      @(posedge clk); #1;
    end

    // reset during a granted read discards the result
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    @(negedge clk);
    check("x_i_gnt", 32'(bus.i_gnt), 32'd1);
    @(posedge clk); #1;
    check("x_i_rdata_pre", bus.i_rdata, 32'h01020304);
    bus.i_addr = 32'h0;
    @(negedge clk);
    check("x_i_gnt2", 32'(bus.i_gnt), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("x_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("x_i_rdata", bus.i_rdata, 32'd0);
    reset = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_lock = 1'b0;
    @(negedge clk);
    check("x_tie_i_gnt", 32'(bus.i_gnt), 32'd1);
    check("x_tie_d_gnt", 32'(bus.d_gnt), 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
